// File: rtl/pio_fifo_pkg.sv
// pio_fifo_pkg
//   Shared constants for the PIO per-state-machine FIFO pair.
//   DEPTH  : per-direction depth in 32-bit words (power of two, >= 2).
//   LW     : level width. A level must hold 2*DEPTH inclusive when the
//            two banks are joined, so LW = $clog2(2*DEPTH) + 1.
//   lim_sel_e : which capacity a FIFO currently has (none/single/double).
//   FLAG_* : bit positions of the sticky debug flags.
package pio_fifo_pkg;

   localparam int DEPTH = 4;
   localparam int LW    = 4;
   localparam int DW    = 32;

   typedef enum logic [1:0] {
      LIM_NONE   = 2'd0,
      LIM_SINGLE = 2'd1,
      LIM_DOUBLE = 2'd2
   } lim_sel_e;

   localparam int FLAG_TX_OVER  = 0;
   localparam int FLAG_TX_STALL = 1;
   localparam int FLAG_RX_UNDER = 2;
   localparam int FLAG_RX_STALL = 3;
   localparam int NFLAGS        = 4;

   // Capacity of one direction given its own join bit and the other one.
   // Both join bits set is treated as no join at all.
   function automatic lim_sel_e mode_sel(input logic own_join, input logic other_join);
      if (own_join && !other_join)
         return LIM_DOUBLE;
      else if (other_join && !own_join)
         return LIM_NONE;
      else
         return LIM_SINGLE;
   endfunction

endpackage

// File: rtl/pio_fifo_core.sv
// pio_fifo_core
//   Circular buffer of 2*DEPTH 32-bit words whose usable capacity is set at
//   run time by `limit` (0, DEPTH or 2*DEPTH). Pointers wrap at `limit`.
//   Ports:
//     clk, rst         : clock, asynchronous active-high reset
//     limit            : current capacity in words
//     flush            : clears level and pointers; discards push/pop
//     push, wdata      : write request and data
//     pop              : read request (head is show-ahead)
//     empty, full      : status (limit 0 reads as both empty and full)
//     level            : occupancy
//     head             : current head word, 0 while empty
//     overflow         : push refused because full and no pop freed a slot
//     underflow        : pop refused because empty
module pio_fifo_core
   import pio_fifo_pkg::*;
#(
   parameter int DEPTH = pio_fifo_pkg::DEPTH,
   parameter int LW    = pio_fifo_pkg::LW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [LW-1:0] limit,
   input  logic          flush,
   input  logic          push,
   input  logic [31:0]   wdata,
   input  logic          pop,
   output logic          empty,
   output logic          full,
   output logic [LW-1:0] level,
   output logic [31:0]   head,
   output logic          overflow,
   output logic          underflow
);

   localparam int SLOTS = 2 * DEPTH;
   localparam int PW    = $clog2(SLOTS);

   logic [DW-1:0]  mem [0:SLOTS-1];
   logic [PW-1:0]  wr_ptr_reg, rd_ptr_reg;
   logic [PW-1:0]  wr_ptr_next, rd_ptr_next;
   logic [LW-1:0]  level_reg, level_next;
   logic           lim_zero, push_acc, pop_acc;

   assign lim_zero = (limit == '0);
   assign empty    = (level_reg == '0);
   assign full     = (level_reg >= limit);

   // A pop on a full FIFO frees the slot the same edge, so a concurrent push
   // is still taken. An empty FIFO never bypasses: the pop is simply refused.
   assign pop_acc  = pop & ~empty & ~flush;
   assign push_acc = push & (~full | pop_acc) & ~flush;

   assign overflow  = push & full & ~pop_acc & ~lim_zero & ~flush;
   assign underflow = pop & empty & ~lim_zero & ~flush;

   assign level = level_reg;
   assign head  = empty ? '0 : mem[rd_ptr_reg];

   always_comb begin
      wr_ptr_next = wr_ptr_reg;
      rd_ptr_next = rd_ptr_reg;
      level_next  = level_reg;
      if (push_acc)
         wr_ptr_next = (LW'(wr_ptr_reg) + LW'(1) >= limit) ? '0 : wr_ptr_reg + PW'(1);
      if (pop_acc)
         rd_ptr_next = (LW'(rd_ptr_reg) + LW'(1) >= limit) ? '0 : rd_ptr_reg + PW'(1);
      case ({push_acc, pop_acc})
         2'b10:   level_next = level_reg + LW'(1);
         2'b01:   level_next = level_reg - LW'(1);
         default: level_next = level_reg;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         level_reg  <= '0;
      end else if (flush) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         level_reg  <= '0;
      end else begin
         wr_ptr_reg <= wr_ptr_next;
         rd_ptr_reg <= rd_ptr_next;
         level_reg  <= level_next;
      end
   end

   // Storage is not reset; head is masked to 0 while empty instead.
   always_ff @(posedge clk) begin
      if (push_acc)
         mem[wr_ptr_reg] <= wdata;
   end

endmodule

// File: rtl/pio_fifo_pair.sv
// pio_fifo_pair
//   TX/RX FIFO pair between the system bus and one PIO state machine.
//   Ports:
//     clk, reset                 : clock, asynchronous active-high reset
//     join_tx, join_rx           : fold both banks into TX or RX
//     sys_tx_push, sys_tx_data   : system write into TX
//     sys_rx_pop, sys_rx_data    : system read from RX (show-ahead)
//     mach_step                  : qualifies every machine-side strobe
//     mach_pull, mach_din,
//     mach_tx_empty              : machine side of TX (PULL)
//     mach_push, mach_dout,
//     mach_rx_full               : machine side of RX (PUSH)
//     tx_level, rx_level,
//     tx_full, rx_empty          : occupancy and system-side status
//     dbg_clear                  : clears sticky flags (set wins)
//     tx_over, tx_stall,
//     rx_under, rx_stall         : sticky debug flags
module pio_fifo_pair
   import pio_fifo_pkg::*;
#(
   parameter int DEPTH = pio_fifo_pkg::DEPTH,
   parameter int LW    = pio_fifo_pkg::LW
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          join_tx,
   input  logic          join_rx,
   input  logic          sys_tx_push,
   input  logic [31:0]   sys_tx_data,
   input  logic          sys_rx_pop,
   output logic [31:0]   sys_rx_data,
   input  logic          mach_step,
   input  logic          mach_pull,
   output logic [31:0]   mach_din,
   output logic          mach_tx_empty,
   input  logic          mach_push,
   input  logic [31:0]   mach_dout,
   output logic          mach_rx_full,
   output logic [LW-1:0] tx_level,
   output logic [LW-1:0] rx_level,
   output logic          tx_full,
   output logic          rx_empty,
   input  logic          dbg_clear,
   output logic          tx_over,
   output logic          tx_stall,
   output logic          rx_under,
   output logic          rx_stall
);

   function automatic logic [LW-1:0] lim_val(input lim_sel_e sel);
      case (sel)
         LIM_DOUBLE: return LW'(2 * DEPTH);
         LIM_SINGLE: return LW'(DEPTH);
         default:    return '0;
      endcase
   endfunction

   logic              join_tx_reg, join_rx_reg;
   logic              flush;
   logic [LW-1:0]     tx_limit, rx_limit;
   logic              tx_pop, rx_push_req, rx_push;
   logic              tx_ovf, tx_unf, rx_ovf_unused, rx_unf;
   logic [NFLAGS-1:0] flags_reg, flag_set;

   assign tx_limit = lim_val(mode_sel(join_tx, join_rx));
   assign rx_limit = lim_val(mode_sel(join_rx, join_tx));

   // Any edge on a join bit reshapes the storage, so both FIFOs are emptied
   // on the edge that ends the change cycle and that cycle's strobes are lost.
   assign flush = (join_tx != join_tx_reg) | (join_rx != join_rx_reg);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         join_tx_reg <= 1'b0;
         join_rx_reg <= 1'b0;
      end else begin
         join_tx_reg <= join_tx;
         join_rx_reg <= join_rx;
      end
   end

   assign tx_pop      = mach_step & mach_pull;
   assign rx_push_req = mach_step & mach_push;
   // The machine sees `full` and stalls, so RX never takes a push while full.
   assign rx_push     = rx_push_req & ~mach_rx_full;

   pio_fifo_core #(.DEPTH(DEPTH), .LW(LW)) u_tx (
      .clk       (clk),
      .rst       (reset),
      .limit     (tx_limit),
      .flush     (flush),
      .push      (sys_tx_push),
      .wdata     (sys_tx_data),
      .pop       (tx_pop),
      .empty     (mach_tx_empty),
      .full      (tx_full),
      .level     (tx_level),
      .head      (mach_din),
      .overflow  (tx_ovf),
      .underflow (tx_unf)
   );

   pio_fifo_core #(.DEPTH(DEPTH), .LW(LW)) u_rx (
      .clk       (clk),
      .rst       (reset),
      .limit     (rx_limit),
      .flush     (flush),
      .push      (rx_push),
      .wdata     (mach_dout),
      .pop       (sys_rx_pop),
      .empty     (rx_empty),
      .full      (mach_rx_full),
      .level     (rx_level),
      .head      (sys_rx_data),
      .overflow  (rx_ovf_unused),
      .underflow (rx_unf)
   );

   always_comb begin
      flag_set                = '0;
      flag_set[FLAG_TX_OVER]  = tx_ovf;
      flag_set[FLAG_TX_STALL] = tx_unf;
      flag_set[FLAG_RX_UNDER] = rx_unf;
      flag_set[FLAG_RX_STALL] = rx_push_req & mach_rx_full & (rx_limit != '0) & ~flush
                                | rx_ovf_unused;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         flags_reg <= '0;
      else
         flags_reg <= (dbg_clear ? '0 : flags_reg) | flag_set;
   end

   assign tx_over  = flags_reg[FLAG_TX_OVER];
   assign tx_stall = flags_reg[FLAG_TX_STALL];
   assign rx_under = flags_reg[FLAG_RX_UNDER];
   assign rx_stall = flags_reg[FLAG_RX_STALL];

endmodule
